// File: rtl/filtro_pkg.sv
// Shared definitions for the sensor conditioning block: debounce FSM state
// encoding and the default persistence length.
package filtro_pkg;

  localparam logic ESTABLE   = 1'b0;
  localparam logic VALIDANDO = 1'b1;

  // 1 ms at 50 MHz
  localparam int DEB_CYCLES_DEF = 50000;

endpackage

// File: rtl/filtro_sensores_antirrebote_canal.sv
// One sensor channel: 2-flop synchronizer, persistence debounce FSM and, with
// FILTRO_SENSORES_LATCH_EN defined, a sticky output cleared by clr_i.
module antirrebote_canal
  import filtro_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic clr_i,
  output logic nivel_o,
  output logic sube_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nivel_q, nivel_d;
  logic             salida_q, salida_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      estado_q <= ESTABLE;
      cnt_q    <= '0;
      nivel_q  <= 1'b0;
      salida_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      nivel_q  <= nivel_d;
      salida_q <= salida_d;
    end
  end

  // The counter is cleared on every exit from VALIDANDO, so it never passes CNT_MAX.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    nivel_d  = nivel_q;
    case (estado_q)
      ESTABLE: begin
        if (sync2_q != nivel_q) begin
          estado_d = VALIDANDO;
          cnt_d    = CNT_W'(1);
        end
      end
      default: begin
        if (sync2_q == nivel_q) begin
          estado_d = ESTABLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
          nivel_d  = ~nivel_q;
          estado_d = ESTABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

`ifdef FILTRO_SENSORES_LATCH_EN
  // A new qualified rise wins over a simultaneous acknowledge.
  always_comb begin
    salida_d = salida_q;
    if (nivel_d && !nivel_q) begin
      salida_d = 1'b1;
    end else if (clr_i && !nivel_q) begin
      salida_d = 1'b0;
    end
  end
`else
  logic clr_unused;
  assign clr_unused = clr_i;

  always_comb begin
    salida_d = nivel_d;
  end
`endif

  assign nivel_o = salida_q;
  assign sube_o  = salida_d & ~salida_q;

endmodule

// File: rtl/filtro_sensores.sv
// Conditions the smoke/temperature/overload lines for the alarm FSM and flags
// new qualified alarms on EVENTO. Optional sticky outputs: FILTRO_SENSORES_LATCH_EN.
module filtro_sensores
  import filtro_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic HUMO_RAW,
  input  logic TEMP_RAW,
  input  logic SOBRECARGA_RAW,
  input  logic CLR,
  output logic HUMO,
  output logic TEMP,
  output logic SOBRECARGA,
  output logic EVENTO
);

  logic [2:0] raw;
  logic [2:0] nivel;
  logic [2:0] sube;
  logic       evento_q;

  assign raw = {SOBRECARGA_RAW, TEMP_RAW, HUMO_RAW};

  for (genvar c = 0; c < 3; c++) begin : g_canal
    antirrebote_canal #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_canal (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .raw_i  (raw[c]),
      .clr_i  (CLR),
      .nivel_o(nivel[c]),
      .sube_o (sube[c])
    );
  end

  // Registered alongside the channel outputs so the pulse lines up with the rise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      evento_q <= 1'b0;
    end else begin
      evento_q <= |sube;
    end
  end

  assign HUMO       = nivel[0];
  assign TEMP       = nivel[1];
  assign SOBRECARGA = nivel[2];
  assign EVENTO     = evento_q;

endmodule

// File: tb/tb_filtro_sensores.sv
// Bench for filtro_sensores with DEB_CYCLES=4: directed scenarios plus random
// stimulus against a sliding-window reference model.
module tb_filtro_sensores;

  localparam int DEB = 4;

  logic CLK = 1'b0;
  logic RST_N, HUMO_RAW, TEMP_RAW, SOBRECARGA_RAW, CLR;
  logic HUMO, TEMP, SOBRECARGA, EVENTO;

  int checks = 0;
  int errors = 0;

  bit m_sync1[3];
  bit m_sync2[3];
  bit m_lvl[3];
  bit m_out[3];
  bit m_ev;
  bit win[3][$];

  filtro_sensores #(.DEB_CYCLES(DEB)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .HUMO_RAW      (HUMO_RAW),
    .TEMP_RAW      (TEMP_RAW),
    .SOBRECARGA_RAW(SOBRECARGA_RAW),
    .CLR           (CLR),
    .HUMO          (HUMO),
    .TEMP          (TEMP),
    .SOBRECARGA    (SOBRECARGA),
    .EVENTO        (EVENTO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_sync1[c] = 0;
      m_sync2[c] = 0;
      m_lvl[c]   = 0;
      m_out[c]   = 0;
      win[c].delete();
    end
    m_ev = 0;
  endtask

  // A level changes once the last DEB synchronized samples all disagree with it.
  task automatic model_edge();
    logic [2:0] r;
    bit all_diff, nl, no;
    r = {SOBRECARGA_RAW, TEMP_RAW, HUMO_RAW};
    m_ev = 0;
    for (int c = 0; c < 3; c++) begin
      win[c].push_back(m_sync2[c]);
      if (win[c].size() > DEB) void'(win[c].pop_front());
      nl = m_lvl[c];
      if (win[c].size() == DEB) begin
        all_diff = 1;
        for (int k = 0; k < win[c].size(); k++)
          if (win[c][k] == m_lvl[c]) all_diff = 0;
        if (all_diff) nl = !m_lvl[c];
      end
`ifdef FILTRO_SENSORES_LATCH_EN
      no = m_out[c];
      if (nl && !m_lvl[c]) no = 1;
      else if (CLR && !m_lvl[c]) no = 0;
`else
      no = nl;
`endif
      if (no && !m_out[c]) m_ev = 1;
      m_lvl[c]   = nl;
      m_out[c]   = no;
      m_sync2[c] = m_sync1[c];
      m_sync1[c] = r[c];
    end
  endtask

  task automatic compare_all();
    chk("HUMO", HUMO, m_out[0]);
    chk("TEMP", TEMP, m_out[1]);
    chk("SOBRECARGA", SOBRECARGA, m_out[2]);
    chk("EVENTO", EVENTO, m_ev);
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST_N) model_edge();
    #1;
    compare_all();
  endtask

  task automatic clear_pulse();
    CLR = 1'b1;
    step();
    step();
    CLR = 1'b0;
    step();
  endtask

  initial begin
    int edge_a, edge_b, evs, seen;
    bit pat[7];
    RST_N = 1'b0;
    HUMO_RAW = 1'b0;
    TEMP_RAW = 1'b0;
    SOBRECARGA_RAW = 1'b0;
    CLR = 1'b0;
    model_reset();
    #2;
    chk("reset_humo", HUMO, 1'b0);
    chk("reset_evento", EVENTO, 1'b0);
    step();
    step();
    #2 RST_N = 1'b1;
    repeat (3) step();

    // Single-channel rise and fall latency
    HUMO_RAW = 1'b1;
    edge_a = 0; evs = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (EVENTO) evs++;
      if (HUMO && edge_a == 0) edge_a = n;
    end
    chk_i("humo_rise_edge", edge_a, 6);
    chk_i("humo_rise_evento", evs, 1);
    HUMO_RAW = 1'b0;
    edge_a = 0; evs = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (EVENTO) evs++;
      if (!HUMO && edge_a == 0) edge_a = n;
    end
`ifndef FILTRO_SENSORES_LATCH_EN
    chk_i("humo_fall_edge", edge_a, 6);
`endif
    chk_i("humo_fall_evento", evs, 0);
    clear_pulse();

    // Short pulses rejected
    pat = '{1, 1, 1, 0, 1, 1, 1};
    seen = 0;
    for (int n = 0; n < 7; n++) begin
      TEMP_RAW = pat[n];
      step();
      if (TEMP) seen = 1;
    end
    TEMP_RAW = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (TEMP) seen = 1;
    end
    chk_i("temp_glitch", seen, 0);

    // Simultaneous rise on two channels
    HUMO_RAW = 1'b1;
    SOBRECARGA_RAW = 1'b1;
    edge_a = 0; edge_b = 0; evs = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (EVENTO) evs++;
      if (HUMO && edge_a == 0) edge_a = n;
      if (SOBRECARGA && edge_b == 0) edge_b = n;
    end
    chk_i("sim_humo_edge", edge_a, 6);
    chk_i("sim_sobre_edge", edge_b, 6);
    chk_i("sim_evento_count", evs, 1);
    HUMO_RAW = 1'b0;
    SOBRECARGA_RAW = 1'b0;
    repeat (10) step();
    clear_pulse();

    // Reset in the middle of a count
    SOBRECARGA_RAW = 1'b1;
    repeat (3) step();
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("midreset_sobre", SOBRECARGA, 1'b0);
    step();
    #2 RST_N = 1'b1;
    edge_a = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (SOBRECARGA && edge_a == 0) edge_a = n;
    end
    chk_i("after_reset_rise_edge", edge_a, 6);
    SOBRECARGA_RAW = 1'b0;
    repeat (10) step();
    clear_pulse();

`ifdef FILTRO_SENSORES_LATCH_EN
    // Sticky output and acknowledge
    TEMP_RAW = 1'b1;
    repeat (8) step();
    chk("latch_temp_set", TEMP, 1'b1);
    TEMP_RAW = 1'b0;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk("latch_clr_while_high", TEMP, 1'b1);
    repeat (8) step();
    chk("latch_temp_held", TEMP, 1'b1);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk("latch_temp_cleared", TEMP, 1'b0);
    repeat (3) step();
`endif

    // Random stimulus against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) HUMO_RAW = ~HUMO_RAW;
      if ($urandom_range(0, 5) == 0) TEMP_RAW = ~TEMP_RAW;
      if ($urandom_range(0, 12) == 0) SOBRECARGA_RAW = ~SOBRECARGA_RAW;
      CLR = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
